// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: data-memory bus between the load/store initiator and the responder.
// The mem_err signal exists only when MEM_ERR_EN is defined.
interface data_mem_responder_if #(parameter int ADDR_W = 16);
    logic [1:0]        mem_cs;
    logic              mem_write_en;
    logic [1:0]        size;
    logic [ADDR_W-1:0] address;
    logic [63:0]       data_in;
    logic [63:0]       data_out;
    logic              data_out_en;
    logic              mem_ready;
    logic              busy;
`ifdef MEM_ERR_EN
    logic              mem_err;
    modport master (output mem_cs, mem_write_en, size, address, data_in,
                    input data_out, data_out_en, mem_ready, busy, mem_err);
    modport slave (input mem_cs, mem_write_en, size, address, data_in,
                   output data_out, data_out_en, mem_ready, busy, mem_err);
`else
    modport master (output mem_cs, mem_write_en, size, address, data_in,
                    input data_out, data_out_en, mem_ready, busy);
    modport slave (input mem_cs, mem_write_en, size, address, data_in,
                   output data_out, data_out_en, mem_ready, busy);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated little-endian data RAM responder (byte/half/word/dword).
// Optional MEM_ERR_EN flags misaligned or out-of-range accesses on mem_err.
module data_mem_responder #(
    parameter int         ADDR_W      = 16,
    parameter int         DEPTH       = 1024,
    parameter int         WAIT_STATES = 2,
    parameter logic [1:0] CS_ID       = 2'b01
) (
    input logic                  i_clock,
    input logic                  i_reset_n,
    data_mem_responder_if.slave  io_bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_we;
    logic [63:0]       r_din, r_dout;
    logic [63:0]       r_mem [DEPTH];
    logic              w_sel, w_idle, w_enter_done, w_we, w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic [2:0]        w_off;
    logic [5:0]        w_sh;
    logic [7:0]        w_be;
    logic [31:0]       w_dw;
    logic [IW-1:0]     w_idx;
    logic [63:0]       w_din, w_word, w_ins, w_wdata, w_mask, w_rdata;
    assign w_sel  = io_bus.mem_cs == CS_ID;
    assign w_idle = r_state == S_IDLE;
    // In IDLE the live bus is used so a zero-wait access decodes on its accept edge.
    assign w_addr = w_idle ? io_bus.address : r_addr;
    assign w_size = w_idle ? io_bus.size : r_size;
    assign w_we   = w_idle ? io_bus.mem_write_en : r_we;
    assign w_din  = w_idle ? io_bus.data_in : r_din;
    assign w_dw   = 32'(w_addr[ADDR_W-1:3]);
    assign w_idx  = IW'(w_dw % DEPTH);
    assign w_off  = (w_size == 2'b01) ? w_addr[2:0] :
                    (w_size == 2'b10) ? {w_addr[2:1], 1'b0} :
                    (w_size == 2'b00) ? {w_addr[2], 2'b00} : 3'd0;
    assign w_sh   = {w_off, 3'b000};
    assign w_be   = ((w_size == 2'b01) ? 8'h01 : (w_size == 2'b10) ? 8'h03 :
                     (w_size == 2'b00) ? 8'h0F : 8'hFF) << w_off;
    assign w_mask = (w_size == 2'b01) ? 64'hFF : (w_size == 2'b10) ? 64'hFFFF :
                    (w_size == 2'b00) ? 64'hFFFF_FFFF : {64{1'b1}};
    assign w_word  = r_mem[w_idx];
    assign w_ins   = w_din << w_sh;
    assign w_rdata = (w_word >> w_sh) & w_mask;
    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign w_wdata[8*i +: 8] = w_be[i] ? w_ins[8*i +: 8] : w_word[8*i +: 8];
    end
`ifdef MEM_ERR_EN
    logic r_err;
    assign w_err = (w_size == 2'b10 && w_addr[0]) || (w_size == 2'b00 && w_addr[1:0] != 2'b00) ||
                   (w_size == 2'b11 && w_addr[2:0] != 3'b000) || w_dw >= DEPTH;
    assign io_bus.mem_err = r_state == S_DONE && r_err;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_err <= 1'b0;
        else if (w_enter_done) r_err <= w_err;
    end
`else
    assign w_err = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !w_sel ? S_IDLE : (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            S_WAIT:  w_next = !w_sel ? S_IDLE : (r_cnt == 4'd1) ? S_DONE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end
    assign w_enter_done = w_next == S_DONE;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_din   <= 64'd0;
            r_dout  <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_idle && w_sel) begin
                r_cnt  <= 4'(WAIT_STATES);
                r_addr <= io_bus.address;
                r_size <= io_bus.size;
                r_we   <= io_bus.mem_write_en;
                r_din  <= io_bus.data_in;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done && !w_we) r_dout <= w_err ? 64'd0 : w_rdata;
        end
    end
    always_ff @(posedge i_clock) begin
        if (i_reset_n && w_enter_done && w_we && !w_err) r_mem[w_idx] <= w_wdata;
    end
    assign io_bus.mem_ready   = r_state == S_DONE;
    assign io_bus.busy        = !w_idle;
    assign io_bus.data_out_en = r_state == S_DONE && !r_we;
    assign io_bus.data_out    = r_dout;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench for data_mem_responder.
// Build with MEM_ERR_EN defined to exercise the error flag.
module tb_data_mem_responder;
    localparam int         AW    = 16;
    localparam int         DEPTH = 1024;
    localparam int         WS    = 2;
    localparam logic [1:0] CS    = 2'b01;
    typedef struct packed {
        logic        ld;
        logic [63:0] d;
        logic        e;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    logic [7:0] mdl [DEPTH*8];
    data_mem_responder_if #(.ADDR_W(AW)) bus ();
    data_mem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS), .CS_ID(CS)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .io_bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Byte-array reference: an access covers size bytes starting at the address aligned down to size.
    function automatic exp_t model(input bit we, input logic [1:0] sz, input logic [AW-1:0] a,
                                   input logic [63:0] d);
        exp_t e;
        int unsigned ai = 32'(a);
        int unsigned n = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : (sz == 2'b00) ? 4 : 8;
        int unsigned base = ((ai / 8) % DEPTH) * 8 + (ai % 8) / n * n;
        e.ld = !we;
        e.d = 64'd0;
`ifdef MEM_ERR_EN
        e.e = (ai % n) != 0 || (ai / 8) >= DEPTH;
`else
        e.e = 1'b0;
`endif
        if (!e.e)
            for (int i = 0; i < int'(n); i++)
                if (we) mdl[base + i] = d[8*i +: 8];
                else e.d[8*i +: 8] = mdl[base + i];
        return e;
    endfunction
    task automatic drive(input bit we, input logic [1:0] sz, input logic [AW-1:0] a, input logic [63:0] d);
        bus.mem_cs = CS;
        bus.mem_write_en = we;
        bus.size = sz;
        bus.address = a;
        bus.data_in = d;
    endtask
    task automatic scramble();
        bus.mem_write_en = 1'($urandom);
        bus.size = 2'($urandom);
        bus.address = AW'($urandom);
        bus.data_in = {$urandom, $urandom};
    endtask
    task automatic wait_ready(output int n, input bit scr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.mem_ready && scr) scramble();
        end while (!bus.mem_ready && n < 40);
    endtask
    task automatic txn(input bit we, input logic [1:0] sz, input logic [AW-1:0] a, input logic [63:0] d);
        int n;
        sbq.push_back(model(we, sz, a, d));
        drive(we, sz, a, d);
        wait_ready(n, 1'b1);
        chk("latency", 64'(n), 64'(WS + 1));
        if (!bus.mem_ready) sbq.delete();
        bus.mem_cs = 2'b00;
        @(negedge clk);
    endtask
    task automatic b2b(input logic [AW-1:0] a, input logic [63:0] d);
        int n;
        sbq.push_back(model(1'b1, 2'b11, a, d));
        drive(1'b1, 2'b11, a, d);
        wait_ready(n, 1'b0);
        sbq.push_back(model(1'b0, 2'b11, a, 64'd0));
        drive(1'b0, 2'b11, a, 64'd0);
        wait_ready(n, 1'b0);
        chk("b2b_gap", 64'(n), 64'(WS + 2));
        bus.mem_cs = 2'b00;
        @(negedge clk);
    endtask
    task automatic abort_store(input logic [AW-1:0] a);
        drive(1'b1, 2'b01, a, 64'hFF);
        @(negedge clk);
        bus.mem_cs = 2'b00;
        @(negedge clk);
        chk("abort_idle", 64'(bus.busy), 64'd0);
        repeat (WS + 2) @(negedge clk);
    endtask
    task automatic reset_mid(input logic [AW-1:0] a);
        drive(1'b1, 2'b11, a, {$urandom, $urandom});
        @(negedge clk);
        chk("busy_wait", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.mem_ready), 64'd0);
        chk("rst_dout_en", 64'(bus.data_out_en), 64'd0);
        chk("rst_dout", bus.data_out, 64'd0);
        bus.mem_cs = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("busy_done", 64'(bus.busy), 64'd1);
                    chk("dout_en", 64'(bus.data_out_en), 64'(e.ld));
                    if (e.ld) chk("load_data", bus.data_out, e.d);
`ifdef MEM_ERR_EN
                    chk("mem_err", 64'(bus.mem_err), 64'(e.e));
`endif
                end
            end
        end
    end
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.mem_cs = 2'b00;
        scramble();
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.mem_ready), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_dout_en", 64'(bus.data_out_en), 64'd0);
        chk("reset_dout", bus.data_out, 64'd0);
`ifdef MEM_ERR_EN
        chk("reset_err", 64'(bus.mem_err), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) txn(1'b1, 2'b11, AW'(i * 8), {$urandom, $urandom});
        txn(1'b1, 2'b11, 16'h40, 64'h0123_4567_89AB_CDEF);
        txn(1'b0, 2'b11, 16'h40, 64'd0);
        txn(1'b1, 2'b01, 16'h43, ({$urandom, $urandom} & ~64'hFF) | 64'hAA);
        txn(1'b0, 2'b01, 16'h43, 64'd0);
        txn(1'b0, 2'b11, 16'h40, 64'd0);
        txn(1'b0, 2'b00, 16'h42, 64'd0);
        abort_store(16'h10);
        txn(1'b0, 2'b01, 16'h10, 64'd0);
        reset_mid(16'h20);
        txn(1'b0, 2'b11, 16'h20, 64'd0);
        for (int c = 0; c < 4; c++) begin
            if (2'(c) == CS) continue;
            scramble();
            bus.mem_cs = 2'(c);
            repeat (3) begin
                @(negedge clk);
                chk("cs_filter_busy", 64'(bus.busy), 64'd0);
            end
        end
        bus.mem_cs = 2'b00;
        @(negedge clk);
        b2b(16'h48, {$urandom, $urandom});
        for (int k = 0; k < 200; k++) begin
            int unsigned hi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            int unsigned a = hi * 8192 + $urandom_range(0, 15) * 8 + $urandom_range(0, 7);
            txn(1'($urandom), 2'($urandom), AW'(a), {$urandom, $urandom});
        end
        repeat (4) @(negedge clk);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
